// File: rtl/wb_snoop_responder_pkg.sv
// Shared definitions for the per-core snoop responder: snoop request
// encodings (common with the arbiter) and the one-hot FSM state codes.
package wb_snoop_responder_pkg;

  // Snoop request type as driven by the arbiter on snoop_type_i.
  localparam logic SNOOP_TYPE_IDLE = 1'b0;
  localparam logic SNOOP_TYPE_READ = 1'b1;

  // One-hot state encodings; an illegal code falls back to IDLE.
  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_REQ   = 5'b00010,
    ST_WAIT  = 5'b00100,
    ST_RESP  = 5'b01000,
    ST_DRAIN = 5'b10000
  } state_e;

  // True when the arbiter is presenting a read snoop.
  function automatic logic is_read(input logic snoop_type);
    return snoop_type == SNOOP_TYPE_READ;
  endfunction

endpackage

// File: rtl/wb_snoop_responder_if.sv
// Snoop bus (arbiter side) and cache lookup port (cache side) seen by one
// snoop responder. Signal suffixes are from the responder's point of view.
interface wb_snoop_responder_if #(
  parameter int aw = 32,
  parameter int dw = 32
);
  // Arbiter snoop bus
  logic [aw-1:0] snoop_adr_i;
  logic          snoop_type_i;
  logic          snoop_en_i;
  logic          snoop_ack_o;
  logic          snoop_hit_o;
  logic [dw-1:0] snoop_dat_o;

  // Cache lookup port
  logic          lkp_req_o;
  logic [aw-1:0] lkp_adr_o;
  logic          lkp_gnt_i;
  logic          lkp_valid_i;
  logic          lkp_hit_i;
  logic [dw-1:0] lkp_dat_i;

  // The responder itself.
  modport slave (
    input  snoop_adr_i, snoop_type_i, snoop_en_i,
    input  lkp_gnt_i, lkp_valid_i, lkp_hit_i, lkp_dat_i,
    output snoop_ack_o, snoop_hit_o, snoop_dat_o,
    output lkp_req_o, lkp_adr_o
  );

  // The environment: arbiter plus cache.
  modport master (
    output snoop_adr_i, snoop_type_i, snoop_en_i,
    output lkp_gnt_i, lkp_valid_i, lkp_hit_i, lkp_dat_i,
    input  snoop_ack_o, snoop_hit_o, snoop_dat_o,
    input  lkp_req_o, lkp_adr_o
  );

endinterface

// File: rtl/wb_snoop_responder_sat_cnt.sv
// Saturating up-counter for debug statistics: sticks at all-ones.
module wb_snoop_sat_cnt #(
  parameter int W = 16
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_d, cnt_q;

  // Next count: advance on inc_i unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/wb_snoop_responder.sv
// Per-core snoop responder: takes a level-held read snoop from the arbiter,
// arbitrates for the data cache lookup port, waits for the tag/data result
// and answers with ack/hit/data held until the arbiter drops the request.
module wb_snoop_responder
  import wb_snoop_responder_pkg::*;
#(
  parameter int aw    = 32,
  parameter int dw    = 32,
  parameter int CNT_W = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  wb_snoop_responder_if.slave  bus,
  output logic [CNT_W-1:0]     snoop_cnt_o,
  output logic [CNT_W-1:0]     hit_cnt_o
);

  state_e        state_d, state_q;
  logic          req_d, req_q;
  logic [aw-1:0] adr_d, adr_q;
  logic          ack_d, ack_q;
  logic          hit_d, hit_q;
  logic [dw-1:0] dat_d, dat_q;
  logic          snoop_inc, hit_inc;

  // Next-state and next-output logic for the snoop FSM.
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    req_d   = req_q;
    adr_d   = adr_q;
    ack_d   = ack_q;
    hit_d   = hit_q;
    dat_d   = dat_q;

    case (state_q)
      ST_IDLE: begin
        if (is_read(bus.snoop_type_i)) begin
          adr_d = bus.snoop_adr_i;
          if (bus.snoop_en_i) begin
            state_d = ST_REQ;
            req_d   = 1'b1;
          end else begin
            // Cache disabled: answer a miss straight away.
            state_d = ST_RESP;
            ack_d   = 1'b1;
            hit_d   = 1'b0;
            dat_d   = '0;
          end
        end
      end

      ST_REQ: begin
        // A grant in the same cycle as the abort still wins: the cache has
        // committed to the lookup, so it has to be followed through.
        if (bus.lkp_gnt_i) begin
          state_d = ST_WAIT;
          req_d   = 1'b0;
        end else if (!is_read(bus.snoop_type_i)) begin
          state_d = ST_IDLE;
          req_d   = 1'b0;
        end
      end

      ST_WAIT: begin
        if (bus.lkp_valid_i) begin
          state_d = ST_RESP;
          ack_d   = 1'b1;
          hit_d   = bus.lkp_hit_i;
          dat_d   = bus.lkp_hit_i ? bus.lkp_dat_i : '0;
        end else if (!is_read(bus.snoop_type_i)) begin
          // Lookup already issued; its result must still be swallowed.
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (bus.lkp_valid_i) begin
          state_d = ST_IDLE;
        end
      end

      ST_RESP: begin
        if (!is_read(bus.snoop_type_i)) begin
          state_d = ST_IDLE;
          ack_d   = 1'b0;
          hit_d   = 1'b0;
          dat_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
        ack_d   = 1'b0;
        hit_d   = 1'b0;
        dat_d   = '0;
      end
    endcase
  end

  // Statistics fire on each entry into RESP.
  assign snoop_inc = (state_d == ST_RESP) && (state_q != ST_RESP);
  assign hit_inc   = snoop_inc && hit_d;

  // FSM state and registered outputs.
  always_ff @(posedge wb_clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      adr_q   <= '0;
      ack_q   <= 1'b0;
      hit_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      adr_q   <= adr_d;
      ack_q   <= ack_d;
      hit_q   <= hit_d;
      dat_q   <= dat_d;
    end
  end

  assign bus.lkp_req_o   = req_q;
  assign bus.lkp_adr_o   = adr_q;
  assign bus.snoop_ack_o = ack_q;
  assign bus.snoop_hit_o = hit_q;
  assign bus.snoop_dat_o = dat_q;

  wb_snoop_sat_cnt #(.W(CNT_W)) u_snoop_cnt (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .inc_i    (snoop_inc),
    .cnt_o    (snoop_cnt_o)
  );

  wb_snoop_sat_cnt #(.W(CNT_W)) u_hit_cnt (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .inc_i    (hit_inc),
    .cnt_o    (hit_cnt_o)
  );

endmodule
